repetition_seq_gen: RTL
=======================

Name: repetition_seq_gen

Overview:
- Stimulus generator producing the `a`/`b` waveforms that the repetition checkers detect.
- Consecutive mode: `a` high for N back-to-back cycles, i.e. a match for a [*N].
- Goto mode: one `a` pulse, then N isolated `b` pulses, i.e. a match for a ##1 b [->N]. Spacing always honours the checker-side constraints: after `a`, `b` stays low for A_GAP cycles; `b` never fires in two consecutive cycles.
- Sits in the bench or formal harness, driving the checker module's `a`/`b` inputs from one start command.

Parameters:
- CNT_W, 8: width of the repetition count, gap and progress fields.
- A_GAP, 4: number of cycles, counted from and including the `a` cycle, during which `b` is held low. Legal range 1..255.
- DEF_B_GAP, 1: minimum low cycles between `b` pulses. Must be ≥1.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: command strobe; accepted only in IDLE.
- mode, input, 1: 0 = consecutive, 1 = goto. Sampled with `start`.
- rep_count, input, CNT_W: N. Sampled with `start`.
- b_gap, input, CNT_W: low cycles between `b` pulses. Sampled with `start`; values below DEF_B_GAP are clamped to DEF_B_GAP.
- a, output, 1: generated `a` signal, registered.
- b, output, 1: generated `b` signal, registered.
- busy, output, 1: high from the first driven cycle through the last `a`/`b` cycle.
- done, output, 1: one-cycle completion pulse.
- rep_idx, output, CNT_W: repetitions emitted so far (`a` cycles in consecutive mode, `b` pulses in goto mode).

Behaviour:
- Reset: state=IDLE; a=0, b=0, busy=0, done=0, rep_idx=0; latched mode/count/gap cleared. Reset mid-sequence aborts immediately at that edge, with no `done`.
- Timing convention: the cycle in which `start` is sampled high in IDLE is cycle 0. All outputs are registered, so the first effect appears in cycle 1.
- States: IDLE, A_RUN, A_PULSE, A_WAIT, B_PULSE, B_WAIT, DONE.
- IDLE:
  - start & rep_count==0 → DONE (done=1 in cycle 1, no a/b activity).
  - start & mode==0 → A_RUN.
  - start & mode==1 → A_PULSE.
- A_RUN: a=1 and busy=1 in cycles 1..N; rep_idx increments each cycle, reaching N in cycle N. Then → DONE, so done=1 and a=0 in cycle N+1.
- A_PULSE: a=1 in cycle 1 only. Then → A_WAIT.
- A_WAIT: a=0, b=0 through cycle A_GAP. Then → B_PULSE.
- B_PULSE: first b=1 in cycle 1+A_GAP. Pulse k (k=0..N-1) occurs in cycle 1+A_GAP+k*(g+1), where g = clamped b_gap. rep_idx increments in the same cycle as each pulse.
- B_WAIT: g cycles with b=0 between pulses.
- Goto completion: after pulse N-1 → DONE, so done=1 in the cycle after the last `b`. Trailing gap is not emitted.
- DONE: a=0, b=0, busy=0, done=1 for exactly one cycle. Then → IDLE.
- `start` is ignored in DONE and in every busy state.
- rep_idx holds its final value until the next accepted `start`, which clears it to 0 in cycle 1 before counting.
- Invariants:
  - a and b are never both 1.
  - In goto mode `a` is high for exactly one cycle.
  - `b` never fires in adjacent cycles.
  - A_GAP and g counters never underflow.
  - rep_count = 2^CNT_W-1 is legal; the counter must not wrap before completion.

Optional Feature:
- Macro: REPETITION_SEQ_GEN_ABORT_EN.
- Defined: adds port `abort` (input, 1).
  - `abort` high in any busy state → a=0, b=0, busy=0 in the next cycle; state → IDLE; no `done`; rep_idx holds.
  - `abort` in IDLE or DONE has no effect.
  - `abort` has priority over an end-of-sequence transition in the same cycle.
- Undefined: no `abort` port; sequences always run to completion or reset.

Test Plan:
- Consecutive: start, mode=0, rep_count=5 → a=1 in cycles 1..5, done in cycle 6, rep_idx=5, b stays 0.
- Goto, single: start, mode=1, rep_count=1, b_gap=1, A_GAP=4 → a in cycle 1, b in cycle 5, done in cycle 6.
- Goto, multiple: mode=1, rep_count=2, b_gap=0 (clamped to 1) → a in cycle 1, b in cycles 5 and 7, done in cycle 8; b never in adjacent cycles.
- Edge cases:
  - rep_count=0 → done in cycle 1, a and b never high.
  - start asserted while busy → ignored; sequence unchanged.
- Reset at cycle 3 of a consecutive N=5 run → a=0 and busy=0 the cycle after reset is sampled; no done.
- With REPETITION_SEQ_GEN_ABORT_EN: abort in cycle 5 of goto N=2 → b never pulses in cycle 7, no done, next start accepted.

Source files
------------

// File: rtl/repetition_seq_gen.sv
// Purpose : stimulus generator driving a [*N] (consecutive) or a ##1 b [->N] (goto) patterns.
// Latency : start sampled in cycle 0, first a/b effect in cycle 1; done pulses one cycle after the last a/b.
// Backpress: none; start is ignored unless IDLE. Optional macro REPETITION_SEQ_GEN_ABORT_EN adds an abort input.
module repetition_seq_gen #(
  parameter int CNT_W     = 8,
  parameter int A_GAP     = 4,
  parameter int DEF_B_GAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] rep_count,
  input  logic [CNT_W-1:0] b_gap,
`ifdef REPETITION_SEQ_GEN_ABORT_EN
  input  logic             abort,
`endif
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rep_idx
);

  typedef enum logic [2:0] {
    IDLE, A_RUN, A_PULSE, A_WAIT, B_PULSE, B_WAIT, DONE
  } state_t;

  // Smallest legal spacing between b pulses.
  localparam logic [CNT_W-1:0] MIN_GAP = CNT_W'(DEF_B_GAP);
  // A_WAIT covers cycles 2..A_GAP, i.e. A_GAP-1 cycles; the timer holds the cycles left after the current one.
  localparam logic [CNT_W-1:0] A_WAIT_INIT = CNT_W'((A_GAP >= 2) ? (A_GAP - 2) : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;   // latched N
  logic [CNT_W-1:0] gap_q, gap_d;   // latched, clamped b spacing
  logic [CNT_W-1:0] tmr_q, tmr_d;   // remaining wait cycles in A_WAIT/B_WAIT
  logic             a_d, b_d, busy_d, done_d;
  logic [CNT_W-1:0] idx_d;
  logic [CNT_W-1:0] gap_in;

  assign gap_in = (b_gap < MIN_GAP) ? MIN_GAP : b_gap;

  // Next-state and next-output decode; outputs are registered so they line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    tmr_d   = tmr_q;
    a_d     = 1'b0;
    b_d     = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    idx_d   = rep_idx;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = rep_count;
          gap_d = gap_in;
          idx_d = '0;
          if (rep_count == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (!mode) begin
            state_d = A_RUN;
            a_d     = 1'b1;
            busy_d  = 1'b1;
            idx_d   = CNT_W'(1);
          end else begin
            state_d = A_PULSE;
            a_d     = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      A_RUN: begin
        // Compare before incrementing so N = 2^CNT_W-1 completes without wrapping.
        if (rep_idx == cnt_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          a_d    = 1'b1;
          busy_d = 1'b1;
          idx_d  = rep_idx + 1'b1;
        end
      end
      A_PULSE: begin
        busy_d = 1'b1;
        if (A_GAP <= 1) begin
          state_d = B_PULSE;
          b_d     = 1'b1;
          idx_d   = rep_idx + 1'b1;
        end else begin
          state_d = A_WAIT;
          tmr_d   = A_WAIT_INIT;
        end
      end
      A_WAIT: begin
        busy_d = 1'b1;
        if (tmr_q == '0) begin
          state_d = B_PULSE;
          b_d     = 1'b1;
          idx_d   = rep_idx + 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      B_PULSE: begin
        // rep_idx already counts the pulse being shown this cycle.
        if (rep_idx == cnt_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = B_WAIT;
          busy_d  = 1'b1;
          tmr_d   = gap_q - 1'b1;
        end
      end
      B_WAIT: begin
        busy_d = 1'b1;
        if (tmr_q == '0) begin
          state_d = B_PULSE;
          b_d     = 1'b1;
          idx_d   = rep_idx + 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef REPETITION_SEQ_GEN_ABORT_EN
    // Abort wins over any end-of-sequence transition; rep_idx keeps its current value.
    if (abort && (state_q inside {A_RUN, A_PULSE, A_WAIT, B_PULSE, B_WAIT})) begin
      state_d = IDLE;
      a_d     = 1'b0;
      b_d     = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      idx_d   = rep_idx;
    end
`endif
  end

  // State, latched command fields and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      tmr_q   <= '0;
      a       <= 1'b0;
      b       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rep_idx <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      tmr_q   <= tmr_d;
      a       <= a_d;
      b       <= b_d;
      busy    <= busy_d;
      done    <= done_d;
      rep_idx <= idx_d;
    end
  end

endmodule
